gpio_ctrl: RTL and testbench

Parametrised, memory-mapped GPIO controller, successor to the fixed 8-bit in/out buffer pair. Provides per-pin direction control, a configurable-depth input synchroniser, an output data register and per-pin edge-triggered interrupt flags with write-1-to-clear. Sits on the core's data-memory bus as a peripheral; pins connect to top-level tri-state pads.

---
 rtl/gpio_ctrl.sv | 138 +++++++++++++
 tb/tb_gpio_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// gpio_ctrl -- memory-mapped GPIO controller.
//
// Per-pin direction control, output data register, SYNC_STAGES-deep input
// synchroniser and, when the GPIO_IRQ_EN macro is defined, per-pin
// edge-triggered interrupt flags with write-1-to-clear. Without GPIO_IRQ_EN,
// offsets 3-5 read 0, their writes are ignored and gpio_irq is tied 0.
//
// Register map (gpio_addr, word offset):
//   0 DATA_IN    RO   last synchroniser stage
//   1 DATA_OUT   RW   drives gpio_pins_out
//   2 DIR        RW   drives gpio_pins_oe (1 = output)
//   3 IRQ_MASK   RW   1 = pin may raise gpio_irq
//   4 EDGE_SEL   RW   1 = rising edge, 0 = falling edge
//   5 IRQ_STATUS W1C  write 1 clears a bit
//   6,7               read 0, writes ignored
//
// Ports:
//   gpio_clk       in   clock, rising edge
//   gpio_rst       in   synchronous active-high reset
//   gpio_we        in   register write strobe
//   gpio_addr      in   [2:0] register select
//   gpio_wdata     in   [WIDTH-1:0] write data
//   gpio_rdata     out  [WIDTH-1:0] read data, combinational from gpio_addr
//   gpio_pins_in   in   [WIDTH-1:0] asynchronous pad inputs
//   gpio_pins_out  out  [WIDTH-1:0] pad output data
//   gpio_pins_oe   out  [WIDTH-1:0] pad output enable
//   gpio_irq       out  level interrupt, OR of (IRQ_STATUS & IRQ_MASK)

module gpio_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             gpio_clk,
    input  logic             gpio_rst,
    input  logic             gpio_we,
    input  logic [2:0]       gpio_addr,
    input  logic [WIDTH-1:0] gpio_wdata,
    output logic [WIDTH-1:0] gpio_rdata,
    input  logic [WIDTH-1:0] gpio_pins_in,
    output logic [WIDTH-1:0] gpio_pins_out,
    output logic [WIDTH-1:0] gpio_pins_oe,
    output logic             gpio_irq
);

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_DIR      = 3'd2;
`ifdef GPIO_IRQ_EN
    localparam logic [2:0] ADDR_MASK     = 3'd3;
    localparam logic [2:0] ADDR_EDGE     = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;
`endif

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_data_out;
    logic [WIDTH-1:0]                  r_dir;
    logic [WIDTH-1:0]                  w_data_in;

    assign w_data_in = r_sync[SYNC_STAGES-1];

    // Every pin is synchronised, including pins driven as outputs, so
    // DATA_IN always returns the level actually seen on the pad.
    always_ff @(posedge gpio_clk) begin
        if (gpio_rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= gpio_pins_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_ff @(posedge gpio_clk) begin
        if (gpio_rst) begin
            r_data_out <= '0;
            r_dir      <= '0;
        end else if (gpio_we) begin
            if (gpio_addr == ADDR_DATA_OUT) r_data_out <= gpio_wdata;
            if (gpio_addr == ADDR_DIR)      r_dir      <= gpio_wdata;
        end
    end

    assign gpio_pins_out = r_data_out;
    assign gpio_pins_oe  = r_dir;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_status;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;

    // prev resets to 0, so a pin already high at reset release reports a
    // rising event once the synchroniser fills.
    assign w_event = ( r_edge &  w_data_in & ~r_prev)
                   | (~r_edge & ~w_data_in &  r_prev);

    assign w_clr = (gpio_we && gpio_addr == ADDR_STATUS) ? gpio_wdata : '0;

    always_ff @(posedge gpio_clk) begin
        if (gpio_rst) begin
            r_prev   <= '0;
            r_mask   <= '0;
            r_edge   <= '0;
            r_status <= '0;
        end else begin
            r_prev <= w_data_in;
            if (gpio_we && gpio_addr == ADDR_MASK) r_mask <= gpio_wdata;
            if (gpio_we && gpio_addr == ADDR_EDGE) r_edge <= gpio_wdata;
            // OR-ing the event after the clear lets a new event win over a
            // simultaneous W1C on the same bit.
            r_status <= (r_status & ~w_clr) | w_event;
        end
    end

    assign gpio_irq = |(r_status & r_mask);
`else
    assign gpio_irq = 1'b0;
`endif

    always_comb begin
        gpio_rdata = '0;
        case (gpio_addr)
            ADDR_DATA_IN:  gpio_rdata = w_data_in;
            ADDR_DATA_OUT: gpio_rdata = r_data_out;
            ADDR_DIR:      gpio_rdata = r_dir;
`ifdef GPIO_IRQ_EN
            ADDR_MASK:     gpio_rdata = r_mask;
            ADDR_EDGE:     gpio_rdata = r_edge;
            ADDR_STATUS:   gpio_rdata = r_status;
`endif
            default:       gpio_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl (WIDTH = 8, SYNC_STAGES = 2). Stimulus
// pushes expected values; a negedge monitor pops and compares them.
// Interrupt checks are selected by GPIO_IRQ_EN, matching the RTL build.

module tb_gpio_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic [7:0] pins_in = 8'h00;
    logic [7:0] pins_out;
    logic [7:0] pins_oe;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    string      q_name[$];
    int         q_kind[$];
    logic [7:0] q_exp[$];

    gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .gpio_clk      (clk),
        .gpio_rst      (rst),
        .gpio_we       (we),
        .gpio_addr     (addr),
        .gpio_wdata    (wdata),
        .gpio_rdata    (rdata),
        .gpio_pins_in  (pins_in),
        .gpio_pins_out (pins_out),
        .gpio_pins_oe  (pins_oe),
        .gpio_irq      (irq)
    );

    always #5 clk = ~clk;

    // kind: 0 = rdata, 1 = pins_out, 2 = pins_oe, 3 = irq
    always @(negedge clk) begin
        while (q_kind.size() > 0) begin
            string      nm;
            int         k;
            logic [7:0] e;
            logic [7:0] act;
            nm = q_name.pop_front();
            k  = q_kind.pop_front();
            e  = q_exp.pop_front();
            case (k)
                0:       act = rdata;
                1:       act = pins_out;
                2:       act = pins_oe;
                default: act = {7'b0, irq};
            endcase
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm, act, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input int k, input logic [7:0] e);
        q_name.push_back(nm);
        q_kind.push_back(k);
        q_exp.push_back(e);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    // Sampled before the next edge, then one edge is consumed.
    task automatic chk_rd(input string nm, input logic [2:0] a, input logic [7:0] e);
        addr = a;
        push(nm, 0, e);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, then every offset reads 0.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        push("rst_oe", 2, 8'h00);
        push("rst_out", 1, 8'h00);
        push("rst_irq", 3, 8'h00);
        for (int a = 0; a < 8; a++) begin
            chk_rd($sformatf("rst_rd%0d", a), 3'(a), 8'h00);
        end

        // Output and direction registers.
        wr(3'd2, 8'hF0);
        wr(3'd1, 8'hA5);
        push("oe_f0", 2, 8'hF0);
        push("out_a5", 1, 8'hA5);
        chk_rd("rd_dout", 3'd1, 8'hA5);
        chk_rd("rd_dir", 3'd2, 8'hF0);
        chk_rd("rd_din0", 3'd0, 8'h00);

        // Synchroniser latency: change, then 1 edge -> old, 2 edges -> new.
        pins_in = 8'h3C;
        tick();
        chk_rd("sync_e1", 3'd0, 8'h00);
        chk_rd("sync_e2", 3'd0, 8'h3C);

        // Unmapped offsets ignore writes.
        wr(3'd6, 8'hFF);
        wr(3'd7, 8'hFF);
        chk_rd("rd6", 3'd6, 8'h00);
        chk_rd("rd7", 3'd7, 8'h00);
        chk_rd("rd_dout_kept", 3'd1, 8'hA5);

`ifdef GPIO_IRQ_EN
        // Falling edges on pins 2-5 with default EDGE_SEL = 0 set status.
        pins_in = 8'h00;
        tick(); tick(); tick(); tick();
        push("irq_masked", 3, 8'h00);
        chk_rd("fall_status", 3'd5, 8'h3C);

        wr(3'd4, 8'h01);
        wr(3'd3, 8'h01);
        wr(3'd5, 8'hFF);
        chk_rd("rd_edge", 3'd4, 8'h01);
        chk_rd("rd_mask", 3'd3, 8'h01);
        chk_rd("clr_all", 3'd5, 8'h00);

        // Pin0 rising: status and irq on the 3rd edge.
        pins_in = 8'h01;
        tick();
        tick();
        push("irq_e2", 3, 8'h00);
        chk_rd("rise_e2", 3'd5, 8'h00);
        push("irq_e3", 3, 8'h01);
        chk_rd("rise_e3", 3'd5, 8'h01);

        wr(3'd5, 8'h01);
        push("irq_clr", 3, 8'h00);
        chk_rd("w1c", 3'd5, 8'h00);

        // Pin0 falling while rising-sensitive: no set.
        pins_in = 8'h00;
        tick(); tick(); tick();
        push("irq_nofall", 3, 8'h00);
        chk_rd("no_fall", 3'd5, 8'h00);

        // Pin3 falling event coincident with W1C of bit 3: set wins.
        pins_in = 8'h08;
        tick(); tick(); tick(); tick();
        chk_rd("pin3_hi", 3'd5, 8'h00);
        pins_in = 8'h00;
        tick();
        tick();
        wr(3'd5, 8'h08);
        push("irq_p3", 3, 8'h00);
        chk_rd("set_wins", 3'd5, 8'h08);
        wr(3'd5, 8'h08);
        chk_rd("p3_clr", 3'd5, 8'h00);
`else
        // IRQ registers absent: offsets 3-5 read 0, irq stays 0.
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'hFF);
        wr(3'd5, 8'hFF);
        pins_in = 8'hFF;
        tick(); tick(); tick();
        push("noirq_a", 3, 8'h00);
        chk_rd("noirq_rd3", 3'd3, 8'h00);
        pins_in = 8'h00;
        tick(); tick(); tick();
        push("noirq_b", 3, 8'h00);
        chk_rd("noirq_rd4", 3'd4, 8'h00);
        chk_rd("noirq_rd5", 3'd5, 8'h00);
        chk_rd("noirq_din", 3'd0, 8'h00);
`endif

        // Reset has priority over a simultaneous write.
        rst   = 1'b1;
        we    = 1'b1;
        addr  = 3'd2;
        wdata = 8'hFF;
        tick();
        we  = 1'b0;
        rst = 1'b0;
        push("rstpri_oe", 2, 8'h00);
        push("rstpri_out", 1, 8'h00);
        push("rstpri_irq", 3, 8'h00);
        chk_rd("rstpri_dir", 3'd2, 8'h00);

        tick();
        tick();
        if (q_kind.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q_kind.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
